// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: control bundle layout, immediate and ALU op codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    // Immediate extension selector (ImmSrc)
    localparam logic [1:0] IMM_SEXT = 2'b00;
    localparam logic [1:0] IMM_ZEXT = 2'b01;
    localparam logic [1:0] IMM_HI   = 2'b10;
    localparam logic [1:0] IMM_RSVD = 2'b11;

    // ALUOp codes as produced by main_control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    // Bit positions inside the flat id_ctrl vector
    localparam int CTRL_REGDST   = 19;
    localparam int CTRL_ALUSRC   = 18;
    localparam int CTRL_MEMTOREG = 17;
    localparam int CTRL_REGWRITE = 16;
    localparam int CTRL_MEMREAD  = 15;
    localparam int CTRL_MEMWRITE = 14;
    localparam int CTRL_BEQ      = 13;
    localparam int CTRL_BNE      = 12;
    localparam int CTRL_JUMP     = 11;
    localparam int CTRL_JAL      = 10;
    localparam int CTRL_ALUOP_LO = 8;
    localparam int CTRL_IMMSRC_LO = 6;
    localparam int CTRL_FUNCT_LO = 0;

    localparam logic [4:0] ZERO_REG = 5'd0;

    // Decoded control bundle as it leaves main_control
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       jump;
        logic       jal;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic [5:0] funct;
    } id_ctrl_t;

    // Same bundle once ImmSrc has been consumed by the extender
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       jump;
        logic       jal;
        logic [1:0] alu_op;
        logic [5:0] funct;
    } ex_ctrl_t;

    function automatic ex_ctrl_t strip_imm_src(input id_ctrl_t c);
        ex_ctrl_t e;
        e.reg_dst    = c.reg_dst;
        e.alu_src    = c.alu_src;
        e.mem_to_reg = c.mem_to_reg;
        e.reg_write  = c.reg_write;
        e.mem_read   = c.mem_read;
        e.mem_write  = c.mem_write;
        e.branch_eq  = c.branch_eq;
        e.branch_ne  = c.branch_ne;
        e.jump       = c.jump;
        e.jal        = c.jal;
        e.alu_op     = c.alu_op;
        e.funct      = c.funct;
        return e;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: load in EX whose rt is read by the ID instruction.
// Latency: combinational, zero cycles.
// Backpressure: raises stall_o to freeze PC and IF/ID; a flush suppresses it.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       id_valid,
    input  logic       id_jump,
    input  logic [1:0] id_imm_src,
    input  logic       id_reg_dst,
    input  logic       id_mem_write,
    input  logic       id_branch_eq,
    input  logic       id_branch_ne,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       flush_i,
    output logic       load_use,
    output logic       stall_o
);

    logic uses_rs;
    logic uses_rt;

    // Which source fields the ID instruction really reads, then the match against the load target
    always_comb begin
        uses_rs  = ~id_jump & (id_imm_src != IMM_HI);
        uses_rt  = id_reg_dst | id_mem_write | id_branch_eq | id_branch_ne;
        load_use = ex_valid & ex_mem_read & id_valid & (ex_rt != ZERO_REG) &
                   ((uses_rs & (id_rs == ex_rt)) | (uses_rt & (id_rt == ex_rt)));
        stall_o  = load_use & ~flush_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with dest-reg resolve, immediate extend, bubble/flush/hold, perf counters.
// Latency: 1 cycle ID to EX; stall_o is combinational from EX state and ID fields.
// Backpressure: hold_i freezes everything; load-use inserts one bubble and asserts stall_o upstream.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          CNT_W  = 16,
    parameter logic [4:0]  RA_REG = 5'd31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  id_ctrl_t          id_ctrl,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic              ex_valid,
    output ex_ctrl_t          ex_ctrl,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_wreg,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              load_use;
    logic [DATA_W-1:0] imm_ext;
    logic [4:0]        wreg_nxt;

    hazard_detect u_hazard (
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_ctrl.mem_read),
        .ex_rt        (ex_rt),
        .id_valid     (id_valid),
        .id_jump      (id_ctrl.jump),
        .id_imm_src   (id_ctrl.imm_src),
        .id_reg_dst   (id_ctrl.reg_dst),
        .id_mem_write (id_ctrl.mem_write),
        .id_branch_eq (id_ctrl.branch_eq),
        .id_branch_ne (id_ctrl.branch_ne),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .flush_i      (flush_i),
        .load_use     (load_use),
        .stall_o      (stall_o)
    );

    // Immediate extension and destination register select; reserved ImmSrc falls back to sign-extend
    always_comb begin
        imm_ext = DATA_W'(signed'(id_imm));
        case (id_ctrl.imm_src)
            IMM_ZEXT: imm_ext = DATA_W'(id_imm);
            IMM_HI:   imm_ext = DATA_W'({id_imm, 16'h0000});
            default:  imm_ext = DATA_W'(signed'(id_imm));
        endcase

        wreg_nxt = ZERO_REG;
        if (id_valid && id_ctrl.reg_write) begin
            if (id_ctrl.jal)
                wreg_nxt = RA_REG;
            else if (id_ctrl.reg_dst)
                wreg_nxt = id_rd;
            else
                wreg_nxt = id_rt;
        end
    end

    // Pipeline register: hold beats flush beats load-use bubble beats normal capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wreg    <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc4     <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (hold_i) begin
            ex_valid <= ex_valid;
        end else if (flush_i || load_use) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wreg    <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc4     <= '0;
            if (flush_i) begin
                if (id_valid && (flush_cnt != CNT_MAX))
                    flush_cnt <= flush_cnt + CNT_W'(1);
            end else if (bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else begin
            ex_valid   <= id_valid;
            ex_ctrl    <= strip_imm_src(id_ctrl);
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_wreg    <= wreg_nxt;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= imm_ext;
            ex_pc4     <= id_pc4;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed ISA cases plus randomized traffic vs a behavioural model.
// Latency: model predicts EX contents one edge after ID; stall_o checked combinationally.
// Backpressure: exercises hold, flush and load-use bubbles including counter saturation.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    id_ctrl_t      id_ctrl = '0;
    logic [4:0]    id_rs = '0, id_rt = '0, id_rd = '0;
    logic [DW-1:0] id_rs_data = '0, id_rt_data = '0, id_pc4 = '0;
    logic [15:0]   id_imm = '0;
    logic          flush_i = 1'b0, hold_i = 1'b0;
    logic          stall_o, ex_valid;
    ex_ctrl_t      ex_ctrl;
    logic [4:0]    ex_rs, ex_rt, ex_wreg;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [CW-1:0] bubble_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    id_ex_stage #(.DATA_W(DW), .CNT_W(CW), .RA_REG(5'd31)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #10 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit            m_valid = 0;
    ex_ctrl_t      m_ctrl = '0;
    bit [4:0]      m_rs = 0, m_rt = 0, m_wreg = 0;
    bit [DW-1:0]   m_rsd = 0, m_rtd = 0, m_imm = 0, m_pc4 = 0;
    int            m_bub = 0, m_fl = 0;
    localparam int SAT = (1 << CW) - 1;

    // Does the ID instruction consume the register the load in EX produces?
    function automatic bit model_load_use();
        bit reads_rs, reads_rt;
        reads_rs = !id_ctrl.jump && (id_ctrl.imm_src != 2'b10);
        reads_rt = id_ctrl.reg_dst || id_ctrl.mem_write || id_ctrl.branch_eq || id_ctrl.branch_ne;
        return m_valid && m_ctrl.mem_read && id_valid && (m_rt != 0) &&
               ((reads_rs && id_rs == m_rt) || (reads_rt && id_rt == m_rt));
    endfunction

    function automatic bit [DW-1:0] model_imm(input bit [15:0] imm, input bit [1:0] sel);
        longint v;
        if (sel == 2'b01)      v = imm;
        else if (sel == 2'b10) v = longint'(imm) * 65536;
        else                   v = longint'(imm) - (imm[15] ? 65536 : 0);
        return v[DW-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_ctrl = '0; m_rs = 0; m_rt = 0; m_wreg = 0;
            m_rsd = 0; m_rtd = 0; m_imm = 0; m_pc4 = 0; m_bub = 0; m_fl = 0;
        end else if (!hold_i) begin
            bit lu;
            lu = model_load_use();
            if (flush_i || lu) begin
                m_valid = 0; m_ctrl = '0; m_rs = 0; m_rt = 0; m_wreg = 0;
                m_rsd = 0; m_rtd = 0; m_imm = 0; m_pc4 = 0;
                if (flush_i) begin
                    if (id_valid && m_fl < SAT) m_fl++;
                end else if (m_bub < SAT) m_bub++;
            end else begin
                m_valid = id_valid;
                m_ctrl.reg_dst = id_ctrl.reg_dst;     m_ctrl.alu_src = id_ctrl.alu_src;
                m_ctrl.mem_to_reg = id_ctrl.mem_to_reg; m_ctrl.reg_write = id_ctrl.reg_write;
                m_ctrl.mem_read = id_ctrl.mem_read;   m_ctrl.mem_write = id_ctrl.mem_write;
                m_ctrl.branch_eq = id_ctrl.branch_eq; m_ctrl.branch_ne = id_ctrl.branch_ne;
                m_ctrl.jump = id_ctrl.jump;           m_ctrl.jal = id_ctrl.jal;
                m_ctrl.alu_op = id_ctrl.alu_op;       m_ctrl.funct = id_ctrl.funct;
                m_rs = id_rs; m_rt = id_rt;
                m_rsd = id_rs_data; m_rtd = id_rt_data; m_pc4 = id_pc4;
                m_imm = model_imm(id_imm, id_ctrl.imm_src);
                if (!id_valid || !id_ctrl.reg_write) m_wreg = 0;
                else if (id_ctrl.jal)                m_wreg = 31;
                else if (id_ctrl.reg_dst)            m_wreg = id_rd;
                else                                 m_wreg = id_rt;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: outputs and inputs are stable at the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.stall_o", stall_o, model_load_use() && !flush_i);
            chk("m.ex_valid", ex_valid, m_valid);
            chk("m.ex_ctrl", ex_ctrl, m_ctrl);
            chk("m.ex_rs", ex_rs, m_rs);
            chk("m.ex_rt", ex_rt, m_rt);
            chk("m.ex_wreg", ex_wreg, m_wreg);
            chk("m.ex_rs_data", ex_rs_data, m_rsd);
            chk("m.ex_rt_data", ex_rt_data, m_rtd);
            chk("m.ex_imm", ex_imm, m_imm);
            chk("m.ex_pc4", ex_pc4, m_pc4);
            chk("m.bubble_cnt", bubble_cnt, m_bub);
            chk("m.flush_cnt", flush_cnt, m_fl);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic id_ctrl_t mk(input bit rdst, asrc, m2r, rw, mr, mw, beq, bne, j, jal,
                                    input bit [1:0] aop, isrc, input bit [5:0] fn);
        id_ctrl_t c;
        c.reg_dst = rdst; c.alu_src = asrc; c.mem_to_reg = m2r; c.reg_write = rw;
        c.mem_read = mr; c.mem_write = mw; c.branch_eq = beq; c.branch_ne = bne;
        c.jump = j; c.jal = jal; c.alu_op = aop; c.imm_src = isrc; c.funct = fn;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input id_ctrl_t c, input bit [4:0] rs, rt, rd,
                         input bit [15:0] imm);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; id_imm = imm;
        id_rs_data = $urandom; id_rt_data = $urandom; id_pc4 = $urandom;
    endtask

    id_ctrl_t c_addi, c_lw, c_add, c_jal, c_ori, c_lui;

    initial begin
        c_addi = mk(0,1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 6'h00);
        c_lw   = mk(0,1,1,1,1,0,0,0,0,0, 2'b00, 2'b00, 6'h00);
        c_add  = mk(1,0,0,1,0,0,0,0,0,0, 2'b10, 2'b00, 6'h20);
        c_jal  = mk(0,0,0,1,0,0,0,0,1,1, 2'b00, 2'b00, 6'h00);
        c_ori  = mk(0,1,0,1,0,0,0,0,0,0, 2'b11, 2'b01, 6'h00);
        c_lui  = mk(0,1,0,1,0,0,0,0,0,0, 2'b00, 2'b10, 6'h00);

        chk_en = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;

        // ADDI $t1,$t0,-4
        drive(1, c_addi, 5'd8, 5'd9, 5'd0, 16'hFFFC);
        tick();
        chk("addi.ex_imm", ex_imm, 32'hFFFF_FFFC);
        chk("addi.ex_wreg", ex_wreg, 5'd9);
        chk("addi.ex_valid", ex_valid, 1'b1);

        // LW $t0 then ADD $t2,$t0,$t1: exactly one bubble
        drive(1, c_lw, 5'd16, 5'd8, 5'd0, 16'h0010);
        tick();
        drive(1, c_add, 5'd8, 5'd9, 5'd10, 16'h5020);
        #1 chk("lu.stall_o", stall_o, 1'b1);
        tick();
        chk("lu.bubble_valid", ex_valid, 1'b0);
        chk("lu.bubble_ctrl", ex_ctrl, '0);
        chk("lu.bubble_cnt", bubble_cnt, 4'd1);
        #1 chk("lu.stall_drop", stall_o, 1'b0);
        tick();
        chk("lu.add_valid", ex_valid, 1'b1);
        chk("lu.add_wreg", ex_wreg, 5'd10);

        // JAL, ORI, LUI
        drive(1, c_jal, 5'd0, 5'd0, 5'd0, 16'h0100);
        tick();
        chk("jal.ex_wreg", ex_wreg, 5'd31);
        chk("jal.ctrl_jal", ex_ctrl.jal, 1'b1);
        drive(1, c_ori, 5'd8, 5'd9, 5'd0, 16'h8000);
        tick();
        chk("ori.ex_imm", ex_imm, 32'h0000_8000);
        drive(1, c_lui, 5'd0, 5'd9, 5'd0, 16'h1234);
        tick();
        chk("lui.ex_imm", ex_imm, 32'h1234_0000);

        // Flush together with load-use, then a 3-cycle hold
        drive(1, c_lw, 5'd16, 5'd8, 5'd0, 16'h0000);
        tick();
        drive(1, c_add, 5'd8, 5'd9, 5'd10, 16'h0000);
        flush_i = 1'b1;
        #1 chk("fl.stall_o", stall_o, 1'b0);
        tick();
        flush_i = 1'b0;
        chk("fl.ex_valid", ex_valid, 1'b0);
        chk("fl.flush_cnt", flush_cnt, 4'd1);
        chk("fl.bubble_cnt", bubble_cnt, 4'd1);
        drive(1, c_addi, 5'd3, 5'd4, 5'd0, 16'h0007);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold.ex_valid", ex_valid, 1'b0);
            chk("hold.flush_cnt", flush_cnt, 4'd1);
            chk("hold.bubble_cnt", bubble_cnt, 4'd1);
        end
        hold_i = 1'b0;
        tick();
        chk("hold.release", ex_valid, 1'b1);

        // 17 more load-use stalls: counter must stick at all-ones
        for (int i = 0; i < 17; i++) begin
            drive(1, c_lw, 5'd16, 5'd8, 5'd0, 16'h0000);
            tick();
            drive(1, c_add, 5'd9, 5'd8, 5'd11, 16'h0000);
            tick();
        end
        chk("sat.bubble_cnt", bubble_cnt, 4'hF);

        // Load to $zero never stalls
        drive(1, c_lw, 5'd16, 5'd0, 5'd0, 16'h0000);
        tick();
        drive(1, c_add, 5'd0, 5'd0, 5'd12, 16'h0000);
        #1 chk("zero.stall_o", stall_o, 1'b0);
        tick();

        // Reset mid-hazard: everything clears without a clock edge
        drive(1, c_lw, 5'd16, 5'd8, 5'd0, 16'h0000);
        tick();
        drive(1, c_add, 5'd8, 5'd9, 5'd10, 16'h0000);
        #1 chk("rst.pre_stall", stall_o, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst.stall_o", stall_o, 1'b0);
        chk("rst.ex_valid", ex_valid, 1'b0);
        chk("rst.ex_wreg", ex_wreg, 5'd0);
        chk("rst.ex_imm", ex_imm, '0);
        chk("rst.bubble_cnt", bubble_cnt, '0);
        chk("rst.flush_cnt", flush_cnt, '0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic, small register space to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            id_ctrl_t c;
            c = id_ctrl_t'($urandom);
            c.mem_read = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 4) != 0, c, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 16'($urandom));
            flush_i = ($urandom_range(0, 9) == 0);
            hold_i  = ($urandom_range(0, 9) == 0);
            tick();
        end
        flush_i = 1'b0;
        hold_i = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
